l_muldiv_unit: RTL and testbench



---
 rtl/l_muldiv_unit.sv | 128 ++++++++++++
 tb/tb_l_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/l_muldiv_unit.sv
// Iterative BITS-wide unsigned multiply/divide stage feeding the register-file write port.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise ops 2/3 complete at once with all-ones.
module l_muldiv_unit #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [2:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result,
    output logic [2:0]      rd_out,
    output logic            write_disable
);

    localparam int CW = $clog2(BITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [BITS-1:0]   opnd_q, opnd_d;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0]   result_q, result_d;
    logic [2:0]        rd_q, rd_d;

    logic              is_div, div_fast;
    logic [BITS-1:0]   fast_result, fin_result;
    logic [BITS:0]     sum;
    logic [2*BITS-1:0] mul_step, acc_step;
`ifdef MULDIV_DIV_EN
    logic [BITS:0]     diff;
    logic [2*BITS-1:0] div_step;
`endif

    // Multiply: {hi, multiplier} shifts right, adding multiplicand into hi when the low bit is set.
    // Divide: {remainder, dividend} shifts left, quotient bits enter at the bottom.
    always_comb begin
        is_div   = op[1];
        sum      = {1'b0, acc_q[2*BITS-1:BITS]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {sum, acc_q[BITS-1:1]} : {1'b0, acc_q[2*BITS-1:1]};
`ifdef MULDIV_DIV_EN
        diff        = acc_q[2*BITS-1:BITS-1] - {1'b0, opnd_q};
        div_step    = diff[BITS] ? {acc_q[2*BITS-2:0], 1'b0}
                                 : {diff[BITS-1:0], acc_q[BITS-2:0], 1'b1};
        acc_step    = op_q[1] ? div_step : mul_step;
        div_fast    = is_div && (b == '0);
        fast_result = op[0] ? a : '1;
        fin_result  = op_q[0] ? acc_step[2*BITS-1:BITS] : acc_step[BITS-1:0];
`else
        acc_step    = mul_step;
        div_fast    = is_div;
        fast_result = '1;
        fin_result  = op_q[1] ? '1
                    : (op_q[0] ? acc_step[2*BITS-1:BITS] : acc_step[BITS-1:0]);
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BITS - 1)) begin
                    state_d  = S_DONE;
                    result_d = fin_result;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d   = op;
                    rd_d   = rd_in;
                    cnt_d  = '0;
                    opnd_d = is_div ? b : a;
                    acc_d  = {{BITS{1'b0}}, (is_div ? a : b)};
                    if (div_fast) begin
                        state_d  = S_DONE;
                        result_d = fast_result;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign write_disable = ~done;
    assign result        = result_q;
    assign rd_out        = rd_q;

endmodule

// File: tb/tb_l_muldiv_unit.sv
// Self-checking bench for l_muldiv_unit: directed cases from the block's test plan plus random ops
// compared against an arithmetic reference model (honours MULDIV_DIV_EN).
module tb_l_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [2:0]  rd_in;
    logic        busy, done, write_disable;
    logic [15:0] result;
    logic [2:0]  rd_out;

    int total = 0;
    int bad   = 0;

    l_muldiv_unit #(.BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .write_disable(write_disable)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_res(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        case (o)
            2'd0: return p[15:0];
            2'd1: return p[31:16];
`ifdef MULDIV_DIV_EN
            2'd2: return (y == 16'd0) ? 16'hFFFF : x / y;
            default: return (y == 16'd0) ? x : x % y;
`else
            default: return 16'hFFFF;
`endif
        endcase
    endfunction

    // Edges after the start edge until done is visible.
    function automatic int model_lat(input logic [1:0] o, input logic [15:0] y);
        if (o[1]) begin
`ifdef MULDIV_DIV_EN
            return (y == 16'd0) ? 0 : 16;
`else
            return 0;
`endif
        end
        return 16;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic [2:0] r);
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        tick();
        start = 1'b0;
        op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); rd_in = 3'($urandom);
    endtask

    task automatic finish_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                             input logic [15:0] y, input logic [2:0] r, input int poke);
        int k = 0;
        bit busy_ok = 1'b1;
        while (done !== 1'b1 && k < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (k == poke) begin
                start = 1'b1; op = ~o; a = 16'($urandom); b = 16'($urandom); rd_in = ~r;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk({tag, ":latency"}, k, model_lat(o, y));
        chk({tag, ":result"}, result, model_res(o, x, y));
        chk({tag, ":rd_out"}, rd_out, r);
        chk({tag, ":wdis_low"}, write_disable, 1'b0);
        chk({tag, ":busy_at_done"}, busy, 1'b0);
        chk({tag, ":busy_during_run"}, busy_ok, 1'b1);
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, ":done_one_cycle"}, done, 1'b0);
        chk({tag, ":wdis_high"}, write_disable, 1'b1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [15:0] rx, ry;
        logic [2:0]  rr;
        bit          saw_done;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
        #3;
        chk("reset:busy", busy, 1'b0);
        chk("reset:done", done, 1'b0);
        chk("reset:result", result, 16'd0);
        chk("reset:rd_out", rd_out, 3'd0);
        chk("reset:wdis", write_disable, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        issue(2'd0, 16'd3, 16'd5, 3'd2);
        finish_op("mul3x5", 2'd0, 16'd3, 16'd5, 3'd2, -1);
        after_done("mul3x5");

        issue(2'd1, 16'hFFFF, 16'hFFFF, 3'd4);
        finish_op("mulh_ff", 2'd1, 16'hFFFF, 16'hFFFF, 3'd4, -1);
        after_done("mulh_ff");
        issue(2'd0, 16'hFFFF, 16'hFFFF, 3'd5);
        finish_op("mul_ff", 2'd0, 16'hFFFF, 16'hFFFF, 3'd5, -1);
        after_done("mul_ff");

        issue(2'd2, 16'd100, 16'd7, 3'd1);
        finish_op("div100_7", 2'd2, 16'd100, 16'd7, 3'd1, -1);
        after_done("div100_7");
        // REM, then a restart in its done cycle.
        issue(2'd3, 16'd100, 16'd7, 3'd3);
        finish_op("rem100_7", 2'd3, 16'd100, 16'd7, 3'd3, -1);
        issue(2'd0, 16'd300, 16'd211, 3'd6);
        finish_op("b2b_mul", 2'd0, 16'd300, 16'd211, 3'd6, -1);
        after_done("b2b_mul");

        issue(2'd2, 16'd1234, 16'd0, 3'd7);
        finish_op("div_by0", 2'd2, 16'd1234, 16'd0, 3'd7, -1);
        after_done("div_by0");
        issue(2'd3, 16'd1234, 16'd0, 3'd0);
        finish_op("rem_by0", 2'd3, 16'd1234, 16'd0, 3'd0, -1);
        after_done("rem_by0");

        issue(2'd0, 16'd517, 16'd93, 3'd2);
        finish_op("ignored_start", 2'd0, 16'd517, 16'd93, 3'd2, 5);
        after_done("ignored_start");

        issue(2'd2, 16'd100, 16'd7, 3'd5);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst:busy", busy, 1'b0);
        chk("midrst:wdis", write_disable, 1'b1);
        chk("midrst:result", result, 16'd0);
        chk("midrst:done", done, 1'b0);
        chk("midrst:rd_out", rd_out, 3'd0);
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst:no_done", saw_done, 1'b0);
        issue(2'd0, 16'd6, 16'd7, 3'd3);
        finish_op("mul6x7", 2'd0, 16'd6, 16'd7, 3'd3, -1);
        after_done("mul6x7");

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            rx = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       ry = 16'd0;
                1:       ry = 16'($urandom_range(1, 15));
                default: ry = 16'($urandom);
            endcase
            rr = 3'($urandom);
            issue(ro, rx, ry, rr);
            finish_op("random", ro, rx, ry, rr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
            if ($urandom_range(0, 1) == 0) after_done("random");
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
